// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared constants and types for the memory bus controller:
//                ROM/RAM region boundary, wait-counter width and the
//                controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    // First address of the RAM region; everything below it is ROM.
    localparam logic [12:0] C_RAM_BASE = 13'h1800;

    // Width of the per-access wait-state counter (0..15 extra cycles).
    localparam int C_WAIT_W = 4;

    typedef logic [C_WAIT_W-1:0] wait_cnt_t;

    // Controller states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_decode
//  Description : Combinational CPU address to memory region decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_decode
    import mem_bus_pkg::*;
(
    input  logic [12:0] i_addr,
    output logic        o_is_rom,
    output logic        o_is_ram
);

    assign o_is_rom = (i_addr < C_RAM_BASE);
    assign o_is_ram = ~o_is_rom;

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_ctrl
//  Description : CPU-to-ROM/RAM bus controller. Detects CPU read/write strobe
//                edges, decodes the region, runs a per-region wait-state
//                counter and holds read data while the read strobe is high.
//                Optional macro MEM_BUS_WP_EN: ROM-region writes raise a
//                sticky bus_err; otherwise they are silently dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int unsigned ROM_WAIT = 2,
    parameter int unsigned RAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic        cpu_halt,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdata_oe,
    output logic        mem_cs_rom,
    output logic        mem_cs_ram,
    output logic        mem_we,
    output logic [12:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  rom_rdata,
    input  logic [7:0]  ram_rdata,
    output logic        busy,
    output logic        bus_err
);
    import mem_bus_pkg::*;

    localparam wait_cnt_t C_ROM_WAIT_CNT = wait_cnt_t'(ROM_WAIT);
    localparam wait_cnt_t C_RAM_WAIT_CNT = wait_cnt_t'(RAM_WAIT);
    localparam wait_cnt_t C_CNT_ONE      = wait_cnt_t'(1);

    state_t      state_q,     state_d;
    wait_cnt_t   cnt_q,       cnt_d;
    logic        rd_prev_q,   rd_prev_d;
    logic        wr_prev_q,   wr_prev_d;
    logic        is_read_q,   is_read_d;
    logic        halt_pend_q, halt_pend_d;
    logic [12:0] addr_q,      addr_d;
    logic [7:0]  wdata_q,     wdata_d;
    logic [7:0]  rdata_q,     rdata_d;
    logic        oe_q,        oe_d;
    logic        cs_rom_q,    cs_rom_d;
    logic        cs_ram_q,    cs_ram_d;
    logic        we_q,        we_d;
    logic        busy_q,      busy_d;
`ifdef MEM_BUS_WP_EN
    logic        bus_err_q,   bus_err_d;
`endif

    logic w_rd_rise;
    logic w_wr_rise;
    logic w_is_rom;
    logic w_is_ram;

    assign w_rd_rise = cpu_rd & ~rd_prev_q;
    assign w_wr_rise = cpu_wr & ~wr_prev_q;

    mem_bus_decode u_decode (
        .i_addr   (cpu_addr),
        .o_is_rom (w_is_rom),
        .o_is_ram (w_is_ram)
    );

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_prev_d   = cpu_rd;
        wr_prev_d   = cpu_wr;
        is_read_d   = is_read_q;
        halt_pend_d = halt_pend_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        oe_d        = oe_q;
        cs_rom_d    = cs_rom_q;
        cs_ram_d    = cs_ram_q;
        we_d        = we_q;
        busy_d      = busy_q;
`ifdef MEM_BUS_WP_EN
        bus_err_d   = bus_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cpu_halt) begin
                    state_d = ST_HALTED;
                end else if (w_rd_rise || w_wr_rise) begin
                    // A simultaneous rd/wr edge is treated as a read.
                    addr_d      = cpu_addr;
                    wdata_d     = cpu_wdata;
                    is_read_d   = w_rd_rise;
                    halt_pend_d = 1'b0;
                    cnt_d       = w_is_rom ? C_ROM_WAIT_CNT : C_RAM_WAIT_CNT;
                    // ROM is never selected for a write; it is read-only.
                    cs_rom_d    = w_rd_rise & w_is_rom;
                    cs_ram_d    = w_is_ram;
                    we_d        = ~w_rd_rise & w_is_ram;
                    busy_d      = 1'b1;
                    state_d     = ST_ACCESS;
`ifdef MEM_BUS_WP_EN
                    if (!w_rd_rise && w_is_rom) begin
                        bus_err_d = 1'b1;
                    end
`endif
                end
            end

            ST_ACCESS: begin
                // A halt arriving mid-access is remembered and honoured
                // once the access has finished.
                if (cpu_halt) begin
                    halt_pend_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    if (is_read_q) begin
                        // For a read, cs_rom_q marks the ROM region.
                        rdata_d = cs_rom_q ? rom_rdata : ram_rdata;
                    end
                    cs_rom_d = 1'b0;
                    cs_ram_d = 1'b0;
                    we_d     = 1'b0;
                    busy_d   = 1'b0;
                    if (halt_pend_q || cpu_halt) begin
                        oe_d    = 1'b0;
                        state_d = ST_HALTED;
                    end else begin
                        oe_d    = is_read_q & cpu_rd;
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end

            ST_HOLD: begin
                if (cpu_halt) begin
                    oe_d    = 1'b0;
                    state_d = ST_HALTED;
                end else if (!cpu_rd && !cpu_wr) begin
                    oe_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    oe_d    = is_read_q & cpu_rd;
                end
            end

            ST_HALTED: begin
                oe_d     = 1'b0;
                cs_rom_d = 1'b0;
                cs_ram_d = 1'b0;
                we_d     = 1'b0;
                busy_d   = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_prev_q   <= 1'b0;
            wr_prev_q   <= 1'b0;
            is_read_q   <= 1'b0;
            halt_pend_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            oe_q        <= 1'b0;
            cs_rom_q    <= 1'b0;
            cs_ram_q    <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_BUS_WP_EN
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_prev_q   <= rd_prev_d;
            wr_prev_q   <= wr_prev_d;
            is_read_q   <= is_read_d;
            halt_pend_q <= halt_pend_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            oe_q        <= oe_d;
            cs_rom_q    <= cs_rom_d;
            cs_ram_q    <= cs_ram_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
`ifdef MEM_BUS_WP_EN
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign cpu_rdata    = rdata_q;
    assign cpu_rdata_oe = oe_q;
    assign mem_cs_rom   = cs_rom_q;
    assign mem_cs_ram   = cs_ram_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign busy         = busy_q;
`ifdef MEM_BUS_WP_EN
    assign bus_err      = bus_err_q;
`else
    assign bus_err      = 1'b0;
`endif

endmodule
`default_nettype wire
